// File: rtl/logger_pkg.sv
// -----------------------------------------------------------------------------
// logger_pkg
// Shared constants and types for the logger frame packer.
//   SYNC_BYTE  first byte of every frame
//   FRAME_LEN  bytes per frame: 4, or 5 when LOGGER_CHK_EN is defined
//   LAST_IDX   byte index of the final byte in a frame
//   state_e    frame engine state encoding
//   frame_chk  checksum helper (LOGGER_CHK_EN builds only)
// Configuration macro: LOGGER_CHK_EN (appends CHK = SEQ ^ DATA[15:8] ^ DATA[7:0]).
// -----------------------------------------------------------------------------
package logger_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef LOGGER_CHK_EN
  localparam int unsigned FRAME_LEN = 5;
`else
  localparam int unsigned FRAME_LEN = 4;
`endif

  localparam int unsigned      IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_NEXT    = 3'd4
  } state_e;

`ifdef LOGGER_CHK_EN
  // Checksum covers SEQ and both data bytes; the SYNC byte is deliberately left out.
  function automatic logic [7:0] frame_chk(input logic [7:0] seq, input logic [15:0] data);
    return seq ^ data[15:8] ^ data[7:0];
  endfunction
`endif

endpackage

// File: rtl/logger_word_fifo.sv
// -----------------------------------------------------------------------------
// logger_word_fifo
// Synchronous first-word-fall-through FIFO for logger samples.
// A push while full is accepted only when a pop happens in the same clock
// (occupancy unchanged); otherwise it is ignored.
// Ports:
//   clk      clock
//   rst_i    asynchronous active-high reset (empties the FIFO)
//   push_i   write request, din_i written when accepted
//   pop_i    read request, ignored when empty
//   din_i    write data
//   dout_o   head word, valid whenever empty_o is low
//   full_o   occupancy == 2**AW
//   empty_o  occupancy == 0
//   count_o  current occupancy
// -----------------------------------------------------------------------------
module logger_word_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en_s, rd_en_s;

  assign full_o  = (count_q == DEPTH);
  assign empty_o = (count_q == {(AW+1){1'b0}});
  assign rd_en_s = pop_i & ~empty_o;
  // A pop in the same clock frees the slot being written, so full does not block.
  assign wr_en_s = push_i & (~full_o | rd_en_s);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/logger_frame_packer.sv
// -----------------------------------------------------------------------------
// logger_frame_packer
// Buffers 16-bit logger samples and serialises each one into the byte frame
//   SYNC(A5), SEQ, DATA[15:8], DATA[7:0] [, CHK]
// handed to the UART transmitter one byte per din_rdy pulse. The engine then
// waits for the transmitter's end-of-byte low pulse on uart_ready, guarded by a
// per-byte watchdog of 2**TIMEOUT_W-1 clocks.
// Configuration macro: LOGGER_CHK_EN (adds the CHK byte, 5-byte frames).
// Ports:
//   clk          system clock
//   rst_din_rdy  asynchronous active-high reset; aborts any frame, empties FIFO
//   s_valid      sample valid        s_ready  FIFO not full
//   s_data       sample word
//   din_rdy      one-clock pulse, din_byte valid for the transmitter
//   din_byte     byte to transmit, held until the next din_rdy
//   uart_ready   transmitter status, low for one clock at end of each byte
//   busy         frame in progress or samples pending
//   ovf_err      sticky: sample offered while FIFO full
//   tmo_err      sticky: watchdog expired waiting for uart_ready low
// -----------------------------------------------------------------------------
module logger_frame_packer
  import logger_pkg::*;
#(
  parameter int unsigned FIFO_AW   = 3,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        rst_din_rdy,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        din_rdy,
  output logic [7:0]  din_byte,
  input  logic        uart_ready,
  output logic        busy,
  output logic        ovf_err,
  output logic        tmo_err
);

  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]     IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_e               state_q;
  logic [15:0]          word_q;
  logic [IDX_W-1:0]     idx_q;
  logic [7:0]           seq_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 din_rdy_q;
  logic [7:0]           din_byte_q;
  logic                 ovf_q;
  logic                 tmo_q;

  logic [7:0]           tx_byte_d;
  logic [TIMEOUT_W-1:0] wd_inc_s;
  logic                 wd_expire_s;
  logic                 fifo_pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [15:0]          fifo_dout_s;
  logic [FIFO_AW:0]     fifo_count_s;

  logger_word_fifo #(
    .WIDTH (16),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (rst_din_rdy),
    .push_i  (s_valid),
    .pop_i   (fifo_pop_s),
    .din_i   (s_data),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign fifo_pop_s  = (state_q == ST_IDLE) & ~fifo_empty_s;
  // Expire on the clock the counter reaches all-ones: WAIT_LO lasts 2**TIMEOUT_W-1 clocks.
  assign wd_inc_s    = wd_q + WD_ONE;
  assign wd_expire_s = &wd_inc_s;

  assign s_ready  = ~fifo_full_s;
  assign busy     = (state_q != ST_IDLE) | (fifo_count_s != {(FIFO_AW+1){1'b0}});
  assign din_rdy  = din_rdy_q;
  assign din_byte = din_byte_q;
  assign ovf_err  = ovf_q;
  assign tmo_err  = tmo_q;

  // Byte selected by the current frame index; SEQ is stable for the whole frame.
  always_comb begin
    tx_byte_d = 8'h00;
    case (idx_q)
      3'd0:    tx_byte_d = SYNC_BYTE;
      3'd1:    tx_byte_d = seq_q;
      3'd2:    tx_byte_d = word_q[15:8];
      3'd3:    tx_byte_d = word_q[7:0];
`ifdef LOGGER_CHK_EN
      3'd4:    tx_byte_d = frame_chk(seq_q, word_q);
`endif
      default: tx_byte_d = 8'h00;
    endcase
  end

  // Frame engine: state, frame register, index, SEQ, watchdog and transmitter handshake.
  always_ff @(posedge clk or posedge rst_din_rdy) begin
    if (rst_din_rdy) begin
      state_q    <= ST_IDLE;
      word_q     <= 16'h0000;
      idx_q      <= {IDX_W{1'b0}};
      seq_q      <= 8'h00;
      wd_q       <= {TIMEOUT_W{1'b0}};
      din_rdy_q  <= 1'b0;
      din_byte_q <= 8'h00;
      tmo_q      <= 1'b0;
    end else begin
      din_rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            word_q  <= fifo_dout_s;
            idx_q   <= {IDX_W{1'b0}};
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          din_byte_q <= tx_byte_d;
          din_rdy_q  <= 1'b1;
          wd_q       <= {TIMEOUT_W{1'b0}};
          state_q    <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!uart_ready) begin
            state_q <= ST_WAIT_HI;
          end else if (wd_expire_s) begin
            tmo_q   <= 1'b1;
            state_q <= ST_NEXT;
          end else begin
            wd_q <= wd_inc_s;
          end
        end
        ST_WAIT_HI: begin
          if (uart_ready) begin
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            seq_q   <= seq_q + 8'd1;
            state_q <= ST_IDLE;
          end else begin
            idx_q   <= idx_q + IDX_ONE;
            state_q <= ST_LOAD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow: sample offered while full with no pop freeing a slot.
  always_ff @(posedge clk or posedge rst_din_rdy) begin
    if (rst_din_rdy) begin
      ovf_q <= 1'b0;
    end else if (s_valid & fifo_full_s & ~fifo_pop_s) begin
      ovf_q <= 1'b1;
    end
  end

endmodule
